// File: rtl/hw_interrupt_controller.sv
// hw_interrupt_controller: synchronises four external request lines and a
// periodic timer. Rising edges become pending requests, and the eligible
// (unmasked) requests are issued to the CPU one at a time as single-cycle
// pulses in fixed priority order, with a guaranteed gap between pulses.
module hw_interrupt_controller #(
  parameter logic [15:0] TIMER_PERIOD = 16'd50000,
  parameter logic [7:0]  HOLDOFF      = 8'd8,
  parameter logic [3:0]  BASE_INDEX   = 4'h8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] irqIn,
  input  logic       timerEnable,
  input  logic       maskWrite,
  input  logic [4:0] maskValue,
  output logic       hardwareInterruptSignal,
  output logic [3:0] hardwareInterruptIndex,
  output logic [4:0] pending
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  s1_r;
  logic [3:0]  s2_r;
  logic [3:0]  s3_r;
  logic [15:0] timer_cnt_r;
  logic [4:0]  mask_r;
  logic [4:0]  pending_r;
  logic [7:0]  hold_cnt_r;
  logic        signal_r;
  logic [3:0]  index_r;

  logic [3:0]  rise_s;
  logic        tick_s;
  logic [4:0]  eligible_s;
  logic        any_s;
  logic [2:0]  win_s;
  logic [4:0]  clr_s;
  logic [4:0]  pending_nxt_s;

  assign hardwareInterruptSignal = signal_r;
  assign hardwareInterruptIndex  = index_r;
  assign pending                 = pending_r;

  // Edge detect, timer tick, priority pick and next pending value (set beats clear).
  always_comb begin
    rise_s     = s2_r & ~s3_r;
    tick_s     = timerEnable && (timer_cnt_r == (TIMER_PERIOD - 16'd1));
    eligible_s = pending_r & ~mask_r;
    any_s      = 1'b1;
    win_s      = 3'd0;
    casez (eligible_s)
      5'b????1: win_s = 3'd0;
      5'b???10: win_s = 3'd1;
      5'b??100: win_s = 3'd2;
      5'b?1000: win_s = 3'd3;
      5'b10000: win_s = 3'd4;
      default: begin
        win_s = 3'd0;
        any_s = 1'b0;
      end
    endcase
    if ((state_r == ST_IDLE) && any_s) begin
      clr_s = 5'b00001 << win_s;
    end else begin
      clr_s = 5'b00000;
    end
    pending_nxt_s = (pending_r & ~clr_s) | {tick_s, rise_s};
  end

  // Two-flop synchroniser per line plus a delay flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_r <= 4'h0;
      s2_r <= 4'h0;
      s3_r <= 4'h0;
    end else begin
      s1_r <= irqIn;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Periodic timer: counts 0..TIMER_PERIOD-1 while enabled, held at 0 otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_cnt_r <= 16'd0;
    end else if (!timerEnable) begin
      timer_cnt_r <= 16'd0;
    end else if (timer_cnt_r == (TIMER_PERIOD - 16'd1)) begin
      timer_cnt_r <= 16'd0;
    end else begin
      timer_cnt_r <= timer_cnt_r + 16'd1;
    end
  end

  // Mask register and pending-request register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_r    <= 5'b00000;
      pending_r <= 5'b00000;
    end else begin
      pending_r <= pending_nxt_s;
      if (maskWrite) begin
        mask_r <= maskValue;
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // Issue state machine with registered pulse and index outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      signal_r   <= 1'b0;
      index_r    <= 4'h0;
      hold_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            index_r  <= BASE_INDEX + {1'b0, win_s};
            signal_r <= 1'b1;
            state_r  <= ST_ISSUE;
          end else begin
            signal_r <= 1'b0;
          end
        end
        ST_ISSUE: begin
          signal_r   <= 1'b0;
          hold_cnt_r <= HOLDOFF;
          state_r    <= ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          signal_r   <= 1'b0;
          hold_cnt_r <= hold_cnt_r - 8'd1;
          if (hold_cnt_r == 8'd1) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_HOLDOFF;
          end
        end
        default: begin
          signal_r   <= 1'b0;
          hold_cnt_r <= 8'd0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hw_interrupt_controller.sv
// Bench for hw_interrupt_controller: directed scenarios plus random traffic,
// each cycle compared against a behavioural model of requests and issue slots.
module tb_hw_interrupt_controller;

  localparam int P = 20;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] irqIn = 4'h0;
  logic       timerEnable = 1'b0;
  logic       maskWrite = 1'b0;
  logic [4:0] maskValue = 5'b00000;
  logic       hardwareInterruptSignal;
  logic [3:0] hardwareInterruptIndex;
  logic [4:0] pending;

  int vectors = 0;
  int errors = 0;

  hw_interrupt_controller #(
    .TIMER_PERIOD(16'd20),
    .HOLDOFF(8'd8),
    .BASE_INDEX(4'h8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .irqIn(irqIn),
    .timerEnable(timerEnable),
    .maskWrite(maskWrite),
    .maskValue(maskValue),
    .hardwareInterruptSignal(hardwareInterruptSignal),
    .hardwareInterruptIndex(hardwareInterruptIndex),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [3:0] hist[$];   // irqIn as sampled at each past edge, oldest first
  logic [4:0] m_pend;
  logic [4:0] m_mask;
  int         m_tcnt;
  int         m_k;       // edges since reset release
  int         m_free;    // first edge at which a new issue may be decided
  logic       m_sig;
  logic [3:0] m_idx;

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back(4'h0);
    m_pend = 5'b0; m_mask = 5'b0; m_tcnt = 0; m_k = 0; m_free = 0;
    m_sig = 1'b0; m_idx = 4'h0;
  endtask

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic step();
    logic [3:0] rise;
    logic       tick;
    logic [4:0] elig;
    logic [4:0] clr;
    @(posedge clk);
    m_k++;
    rise = hist[hist.size()-2] & ~hist[hist.size()-3];
    tick = timerEnable && (m_tcnt == P - 1);
    elig = m_pend & ~m_mask;
    clr = 5'b0;
    m_sig = 1'b0;
    if (m_k >= m_free && elig != 5'b0) begin
      for (int i = 4; i >= 0; i--) if (elig[i]) begin
        m_sig = 1'b1; m_idx = 4'(8 + i); clr = 5'b00001 << i;
      end
      m_free = m_k + H + 2;
    end
    m_pend = (m_pend & ~clr) | {tick, rise};
    m_tcnt = timerEnable ? ((m_tcnt == P - 1) ? 0 : m_tcnt + 1) : 0;
    if (maskWrite) m_mask = maskValue;
    hist.push_back(irqIn);
    if (hist.size() > 4) void'(hist.pop_front());
    #1;
  endtask

  task automatic test_reset(input logic ten);
    rst = 1'b0; irqIn = 4'h0; timerEnable = ten; maskWrite = 1'b0; maskValue = 5'b0;
    #1;
    vectors++;
    if ({hardwareInterruptSignal, hardwareInterruptIndex, pending} !== 10'b0) begin
      errors++;
      $display("FAIL reset: got sig=%b idx=%h pend=%b, want all zero",
               hardwareInterruptSignal, hardwareInterruptIndex, pending);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    int t_pulse = -1;
    test_reset(1'b0);
    irqIn = 4'b0100;
    for (int c = 1; c <= 104; c++) begin
      step();
      vectors++;
      if ({hardwareInterruptSignal, hardwareInterruptIndex, pending} !== {m_sig, m_idx, m_pend}) begin
        errors++;
        $display("FAIL basic c%0d: got %b/%h/%b want %b/%h/%b", c, hardwareInterruptSignal,
                 hardwareInterruptIndex, pending, m_sig, m_idx, m_pend);
      end
      if (hardwareInterruptSignal) begin
        if (t_pulse < 0) t_pulse = c;
        else begin
          errors++;
          $display("FAIL basic_extra_pulse: got pulse at c%0d, want none", c);
        end
      end
    end
    vectors++;
    if (t_pulse != 4 || hardwareInterruptIndex !== 4'hA || pending !== 5'b0) begin
      errors++;
      $display("FAIL basic_latency: got pulse at %0d idx=%h pend=%b, want 4 idx=a pend=0",
               t_pulse, hardwareInterruptIndex, pending);
    end
    irqIn = 4'h0;
  endtask

  task automatic test_priority();
    int t1 = -1;
    int t2 = -1;
    logic [3:0] i1 = 4'h0;
    logic [3:0] i2 = 4'h0;
    test_reset(1'b0);
    irqIn = 4'b1010;
    for (int c = 1; c <= 30; c++) begin
      step();
      vectors++;
      if ({hardwareInterruptSignal, hardwareInterruptIndex, pending} !== {m_sig, m_idx, m_pend}) begin
        errors++;
        $display("FAIL priority c%0d: got %b/%h/%b want %b/%h/%b", c, hardwareInterruptSignal,
                 hardwareInterruptIndex, pending, m_sig, m_idx, m_pend);
      end
      if (hardwareInterruptSignal && t1 < 0) begin t1 = c; i1 = hardwareInterruptIndex; end
      else if (hardwareInterruptSignal && t2 < 0) begin t2 = c; i2 = hardwareInterruptIndex; end
    end
    vectors++;
    if (i1 !== 4'h9 || i2 !== 4'hB || t1 < 0 || t2 - t1 != 10) begin
      errors++;
      $display("FAIL priority_order: got %h@%0d %h@%0d, want 9 then b 10 cycles later",
               i1, t1, i2, t2);
    end
    irqIn = 4'h0;
  endtask

  task automatic test_mask();
    int wait_c = 0;
    test_reset(1'b0);
    maskWrite = 1'b1; maskValue = 5'b00001;
    step();
    maskWrite = 1'b0;
    irqIn = 4'b0001;
    for (int c = 1; c <= 12; c++) begin
      step();
      vectors++;
      if ({hardwareInterruptSignal, hardwareInterruptIndex, pending} !== {m_sig, m_idx, m_pend}) begin
        errors++;
        $display("FAIL mask c%0d: got %b/%h/%b want %b/%h/%b", c, hardwareInterruptSignal,
                 hardwareInterruptIndex, pending, m_sig, m_idx, m_pend);
      end
    end
    vectors++;
    if (pending !== 5'b00001) begin
      errors++;
      $display("FAIL mask_held: got pend=%b, want 00001", pending);
    end
    maskWrite = 1'b1; maskValue = 5'b00000;
    do begin
      step();
      maskWrite = 1'b0;
      wait_c++;
    end while (!hardwareInterruptSignal && wait_c < 5);
    vectors++;
    if (wait_c > 2 || hardwareInterruptIndex !== 4'h8) begin
      errors++;
      $display("FAIL mask_release: got pulse after %0d idx=%h, want <=2 idx=8",
               wait_c, hardwareInterruptIndex);
    end
    irqIn = 4'h0;
  endtask

  task automatic test_timer();
    int last = -1;
    int npulse = 0;
    test_reset(1'b1);
    for (int c = 1; c <= 110; c++) begin
      step();
      vectors++;
      if ({hardwareInterruptSignal, hardwareInterruptIndex, pending} !== {m_sig, m_idx, m_pend}) begin
        errors++;
        $display("FAIL timer c%0d: got %b/%h/%b want %b/%h/%b", c, hardwareInterruptSignal,
                 hardwareInterruptIndex, pending, m_sig, m_idx, m_pend);
      end
      if (hardwareInterruptSignal) begin
        vectors++;
        if (hardwareInterruptIndex !== 4'hC || (last >= 0 && c - last != P) || (last < 0 && c != P + 1)) begin
          errors++;
          $display("FAIL timer_period: got idx=%h at c%0d (prev %0d), want c at 20-cycle spacing",
                   hardwareInterruptIndex, c, last);
        end
        last = c; npulse++;
      end
    end
    timerEnable = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      step();
      vectors++;
      if (hardwareInterruptSignal !== m_sig || pending !== m_pend || (c > 12 && hardwareInterruptSignal)) begin
        errors++;
        $display("FAIL timer_off c%0d: got sig=%b pend=%b want sig=%b pend=%b", c,
                 hardwareInterruptSignal, pending, m_sig, m_pend);
      end
    end
    vectors++;
    if (dut.timer_cnt_r !== 16'd0 || npulse != 5) begin
      errors++;
      $display("FAIL timer_stop: got cnt=%0d pulses=%0d, want 0 and 5", dut.timer_cnt_r, npulse);
    end
  endtask

  task automatic test_collision();
    int t1 = -1;
    test_reset(1'b0);
    maskWrite = 1'b1; maskValue = 5'b00010;
    step();
    maskWrite = 1'b0;
    irqIn = 4'b0010;
    repeat (3) step();
    irqIn = 4'b0000;
    repeat (5) step();
    irqIn = 4'b0010;
    step();
    maskWrite = 1'b1; maskValue = 5'b00000;
    step();
    maskWrite = 1'b0;
    step();
    vectors++;
    if (hardwareInterruptSignal !== 1'b1 || hardwareInterruptIndex !== 4'h9 || pending[1] !== 1'b1) begin
      errors++;
      $display("FAIL collision_first: got sig=%b idx=%h pend=%b, want 1/9/pend[1]=1",
               hardwareInterruptSignal, hardwareInterruptIndex, pending);
    end
    for (int c = 1; c <= 15; c++) begin
      step();
      vectors++;
      if ({hardwareInterruptSignal, hardwareInterruptIndex, pending} !== {m_sig, m_idx, m_pend}) begin
        errors++;
        $display("FAIL collision c%0d: got %b/%h/%b want %b/%h/%b", c, hardwareInterruptSignal,
                 hardwareInterruptIndex, pending, m_sig, m_idx, m_pend);
      end
      if (hardwareInterruptSignal && t1 < 0) t1 = c;
    end
    vectors++;
    if (t1 != 10) begin
      errors++;
      $display("FAIL collision_second: got second pulse at +%0d, want +10", t1);
    end
    irqIn = 4'h0;
  endtask

  task automatic test_midholdoff_reset();
    test_reset(1'b0);
    irqIn = 4'b0110;
    repeat (8) step();
    vectors++;
    if (pending !== 5'b00100 || hardwareInterruptIndex !== 4'h9) begin
      errors++;
      $display("FAIL holdoff_setup: got pend=%b idx=%h, want 00100/9", pending, hardwareInterruptIndex);
    end
    test_reset(1'b0);
    for (int c = 1; c <= 30; c++) begin
      step();
      vectors++;
      if ({hardwareInterruptSignal, hardwareInterruptIndex, pending} !== {m_sig, m_idx, m_pend} ||
          hardwareInterruptSignal) begin
        errors++;
        $display("FAIL holdoff_reset c%0d: got %b/%h/%b want %b/%h/%b", c, hardwareInterruptSignal,
                 hardwareInterruptIndex, pending, m_sig, m_idx, m_pend);
      end
    end
  endtask

  task automatic test_random();
    test_reset(1'b0);
    for (int c = 1; c <= 1500; c++) begin
      if ($urandom_range(0, 7) == 0) irqIn = irqIn ^ 4'($urandom_range(0, 15));
      maskWrite = ($urandom_range(0, 15) == 0);
      maskValue = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) timerEnable = ~timerEnable;
      step();
      vectors++;
      if ({hardwareInterruptSignal, hardwareInterruptIndex, pending} !== {m_sig, m_idx, m_pend}) begin
        errors++;
        $display("FAIL random c%0d: got %b/%h/%b want %b/%h/%b", c, hardwareInterruptSignal,
                 hardwareInterruptIndex, pending, m_sig, m_idx, m_pend);
      end
    end
    maskWrite = 1'b0; timerEnable = 1'b0; irqIn = 4'h0;
  endtask

  initial begin
    model_reset();
    test_reset(1'b0);
    test_basic();
    test_priority();
    test_mask();
    test_timer();
    test_collision();
    test_midholdoff_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hw_interrupt_controller.md
# hw_interrupt_controller

Upstream feeder for the CPU's `hardwareInterruptSignal` / `hardwareInterruptIndex` inputs, which go into the CPU's interrupt arbitration logic. It synchronises four asynchronous external request lines and runs an internal periodic timer as a fifth source. Rising edges are latched as pending requests, and mask bits gate which requests are eligible. Eligible requests are issued to the CPU as single-cycle pulses, with a fixed priority and a guaranteed minimum spacing between pulses.

## Interface
- `TIMER_PERIOD`, default 16'd50000: timer tick period in clk cycles; legal range 2..65535.
- `HOLDOFF`, default 8'd8: number of idle cycles forced after each issued pulse; must be ≥1.
- `BASE_INDEX`, default 4'h8: index reported for source 0. Source i reports `BASE_INDEX+i`, and the timer reports `BASE_INDEX+4`. Arithmetic is 4-bit and wraps.

Ports:
- `clk` in, 1: system clock.
- `rst` in, 1: asynchronous, active-low reset.
- `irqIn` in, 4: raw asynchronous request levels.
- `timerEnable` in, 1: runs the timer when high.
- `maskWrite` in, 1: when high, loads `maskValue` into the mask register at the clock edge.
- `maskValue` in, 5: new mask value. A 1 blocks issue of that source; bit 4 is the timer.
- `hardwareInterruptSignal` out, 1: one-cycle request pulse to the CPU.
- `hardwareInterruptIndex` out, 4: index of the last issued request.
- `pending` out, 5: pending-request register, exposed for VGA debug.

## Operation
- **Synchronisers.** Each `irqIn[i]` passes through two flip-flops, `s1` then `s2`, followed by a delay flop `s3`.
  - A rising edge is detected when `s2 & ~s3`; this sets `pending[i]`.
  - Levels are not tracked: a held-high line produces exactly one request.
- **Timer.**
  - 16-bit counter, counting 0..`TIMER_PERIOD-1` while `timerEnable` is high.
  - At terminal count it wraps to 0 and sets `pending[4]`.
  - When `timerEnable` is low, the counter is synchronously cleared to 0.
- **Mask.**
  - Pending bits latch regardless of the mask. Masked bits stay pending and issue later, once unmasked.
  - A mask write takes effect from the next cycle. An IDLE decision made in the same cycle as the write uses the old mask.
- **Priority.** Among `pending & ~mask`, the lowest bit wins: source 0 is highest priority, the timer is lowest.
- **State machine** (states IDLE, ISSUE, HOLDOFF):
  - **IDLE:** if any bit is eligible, latch the winner's index into `hardwareInterruptIndex`, clear that pending bit, and go to ISSUE. Otherwise stay in IDLE.
  - **ISSUE:** `hardwareInterruptSignal`=1 for this single cycle. Load the holdoff counter with `HOLDOFF` and go to HOLDOFF.
  - **HOLDOFF:** decrement the counter each cycle. On the cycle it reads 1, go to IDLE. HOLDOFF therefore lasts exactly `HOLDOFF` cycles.
- **Simultaneous events.**
  - A set and a clear of the same pending bit in one cycle: the set wins, so the new event is retained and issues later.
  - A new edge on a bit that is already pending merges into it; only one pulse is issued.
  - Several edges in the same cycle: all latch, and they issue one by one in priority order.
- `hardwareInterruptIndex` holds its value until the next issue.

## Timing
- **Reset (`rst`=0), applied asynchronously:**
  - State = IDLE.
  - `hardwareInterruptSignal`=0, `hardwareInterruptIndex`=4'h0, `pending`=0.
  - Mask=0 (all sources enabled); timer counter=0; holdoff counter=0; `s1`/`s2`/`s3`=0.
- **Reset mid-pulse or mid-holdoff:** outputs drop immediately and all pending requests are lost.
- **Line high at reset release:** a line already high when reset releases counts as a rising edge. This is intended behaviour.
- **Request latency.** Let `irqIn` rise and settle before edge E0. Then:
  - `s1`=1 after E0 and `s2`=1 after E1.
  - `pending` is set at E2.
  - The state is ISSUE after E3, so the pulse is high from E3 to E4.
  - Total: 4 edges from input to pulse.
- **Timer latency.** The counter reaches `TIMER_PERIOD-1` at edge T. Then `pending[4]` sets at T+1 and the pulse is high after T+2, if eligible.
- **Pulse spacing.** Back-to-back pulses are separated by exactly `HOLDOFF+2` cycles (rising edge to rising edge); with the default, 10 cycles.

## Test plan
- **Basic request.** Reset, then raise `irqIn[2]` and hold it. Expect one pulse, 4 edges later, with index 4'hA. After that, no further pulse over 100 cycles, and `pending`=0.
- **Priority and spacing.** Raise `irqIn[3]` and `irqIn[1]` in the same cycle. Expect index 4'h9 first, then 4'hB exactly 10 cycles later.
- **Masking.** Write mask 5'b00001, then raise `irqIn[0]`. Expect `pending[0]`=1 and no pulse. Write mask 0; expect a pulse with index 4'h8 at most 2 cycles later.
- **Timer.** Set `TIMER_PERIOD`=20 and `timerEnable`=1 from reset. Expect pulses with index 4'hC every 20 cycles. Drop `timerEnable`; expect no pulses and the counter reads 0.
- **Collision.** Create a second rising edge on source 1 in the same cycle its pending bit is being cleared by issue. Expect `pending[1]` to stay 1 and a second 4'h9 pulse exactly 10 cycles after the first.
- **Mid-holdoff reset.** Assert `rst` during HOLDOFF with source 2 pending. Expect all outputs 0 immediately, and no pulse after release while `irqIn` is low.
